// File: rtl/dmem_pkg.sv
// Shared definitions for the RV32I data memory LSU: funct3 codes, FSM states
// and error-cause bit positions.
package dmem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int unsigned ERR_W        = 3;
    localparam int unsigned ERR_MISALIGN = 0;
    localparam int unsigned ERR_ILLEGAL  = 1;
    localparam int unsigned ERR_RANGE    = 2;

    typedef logic [ERR_W-1:0] err_cause_t;

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering for RV32I sub-word accesses: store byte-enables and
// replicated write data, load extraction/extension, and size/funct3 fault flags.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic        i_is_store,
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rword,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    output logic [31:0] o_rdata,
    output logic        o_misaligned,
    output logic        o_illegal
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_byte = i_rword[{i_addr_lo, 3'b000} +: 8];
    assign w_half = i_addr_lo[1] ? i_rword[31:16] : i_rword[15:0];

    // Write data is replicated across lanes so the byte-enable alone selects the target.
    always_comb begin
        o_be         = '0;
        o_wdata      = '0;
        o_rdata      = '0;
        o_misaligned = 1'b0;
        o_illegal    = 1'b0;
        case (i_funct3)
            F3_B: begin
                o_be    = 4'b0001 << i_addr_lo;
                o_wdata = {4{i_wdata[7:0]}};
                o_rdata = {{24{w_byte[7]}}, w_byte};
            end
            F3_H: begin
                o_be         = i_addr_lo[1] ? 4'b1100 : 4'b0011;
                o_wdata      = {2{i_wdata[15:0]}};
                o_rdata      = {{16{w_half[15]}}, w_half};
                o_misaligned = i_addr_lo[0];
            end
            F3_W: begin
                o_be         = '1;
                o_wdata      = i_wdata;
                o_rdata      = i_rword;
                o_misaligned = |i_addr_lo;
            end
            F3_BU: begin
                o_rdata   = {24'b0, w_byte};
                o_illegal = i_is_store;
            end
            F3_HU: begin
                o_rdata      = {16'b0, w_half};
                o_misaligned = i_addr_lo[0];
                o_illegal    = i_is_store;
            end
            default: o_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/data_memory_lsu.sv
// Word-organised RV32I data memory with valid/ready request port, fixed read
// latency and a one-cycle response pulse carrying load data or a fault flag.
module data_memory_lsu
    import dmem_pkg::*;
#(
    parameter int DEPTH        = 64,
    parameter int READ_LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int AW = $clog2(DEPTH);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [2:0]  r_cnt;
    logic [2:0]  w_cnt_nxt;
    logic [31:0] r_mem [DEPTH];
    logic [31:0] r_rdata;
    logic        r_err;

    logic          w_accept;
    logic [AW-1:0] w_idx;
    logic [31:0]   w_rword;
    logic [3:0]    w_be;
    logic [31:0]   w_wdata_sh;
    logic [31:0]   w_rdata_ext;
    logic          w_misaligned;
    logic          w_illegal;
    err_cause_t    w_cause;
    logic          w_fault;

    assign req_ready = (r_state != WAIT);
    assign w_accept  = req_valid && req_ready;
    assign w_idx     = req_addr[AW+1:2];
    assign w_rword   = r_mem[w_idx];

    dmem_lane_align u_align (
        .i_is_store   (req_we),
        .i_funct3     (req_funct3),
        .i_addr_lo    (req_addr[1:0]),
        .i_wdata      (req_wdata),
        .i_rword      (w_rword),
        .o_be         (w_be),
        .o_wdata      (w_wdata_sh),
        .o_rdata      (w_rdata_ext),
        .o_misaligned (w_misaligned),
        .o_illegal    (w_illegal)
    );

    always_comb begin
        w_cause               = '0;
        w_cause[ERR_MISALIGN] = w_misaligned;
        w_cause[ERR_ILLEGAL]  = w_illegal;
        w_cause[ERR_RANGE]    = |req_addr[31:AW+2];
    end

    assign w_fault = |w_cause;

    // Memory array is deliberately not reset; a store commits on its acceptance edge.
    always_ff @(posedge clk) begin
        if (w_accept && req_we && !w_fault) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (w_be[i]) begin
                    r_mem[w_idx][8*i +: 8] <= w_wdata_sh[8*i +: 8];
                end
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            WAIT: begin
                if (r_cnt <= 3'd1) begin
                    w_state_nxt = RESP;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt - 3'd1;
                end
            end
            RESP:    w_state_nxt = IDLE;
            default: ;
        endcase
        // A new acceptance (IDLE or RESP) overrides the default progression.
        if (w_accept) begin
            w_state_nxt = (READ_LATENCY == 1) ? RESP : WAIT;
            w_cnt_nxt   = 3'(READ_LATENCY - 1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_accept) begin
                r_rdata <= (req_we || w_fault) ? '0 : w_rdata_ext;
                r_err   <= w_fault;
            end
        end
    end

    assign rsp_valid = (r_state == RESP);
    assign rsp_rdata = r_rdata;
    assign rsp_err   = r_err;

endmodule

// File: tb/tb_data_memory_lsu.sv
// Scoreboard bench for data_memory_lsu: one instance at READ_LATENCY=1 and one
// at READ_LATENCY=3, each with its own expected-response queue and monitor.
module tb_data_memory_lsu;
    import dmem_pkg::*;

    localparam int DEPTH = 64;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int unsigned due;
    } rsp_t;

    logic clk = 1'b0;
    logic a_rst_n = 1'b0;
    logic b_rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        a_valid, a_ready, a_we, a_rsp_valid, a_err;
    logic [2:0]  a_f3;
    logic [31:0] a_addr, a_wdata, a_rdata;
    logic        b_valid, b_ready, b_we, b_rsp_valid, b_err;
    logic [2:0]  b_f3;
    logic [31:0] b_addr, b_wdata, b_rdata;

    int n_checks = 0;
    int n_errors = 0;
    int unsigned cyc = 0;
    rsp_t qa[$];
    rsp_t qb[$];

    always @(posedge clk) cyc <= cyc + 1;

    data_memory_lsu #(.DEPTH(DEPTH), .READ_LATENCY(1)) u_dut1 (
        .clk(clk), .rst_n(a_rst_n), .req_valid(a_valid), .req_ready(a_ready),
        .req_we(a_we), .req_funct3(a_f3), .req_addr(a_addr), .req_wdata(a_wdata),
        .rsp_valid(a_rsp_valid), .rsp_rdata(a_rdata), .rsp_err(a_err)
    );

    data_memory_lsu #(.DEPTH(DEPTH), .READ_LATENCY(3)) u_dut3 (
        .clk(clk), .rst_n(b_rst_n), .req_valid(b_valid), .req_ready(b_ready),
        .req_we(b_we), .req_funct3(b_f3), .req_addr(b_addr), .req_wdata(b_wdata),
        .rsp_valid(b_rsp_valid), .rsp_rdata(b_rdata), .rsp_err(b_err)
    );

    // Scoreboard monitors: every response pulse must match the oldest expectation, on time.
    always @(negedge clk) begin
        rsp_t e;
        if (a_rsp_valid === 1'b1) begin
            n_checks++;
            if (qa.size() == 0) begin
                n_errors++;
                $display("FAIL rsp1_unexpected: pulse rdata=%h err=%b, required no response", a_rdata, a_err);
            end else begin
                e = qa.pop_front();
                if (a_rdata !== e.rdata || a_err !== e.err || cyc != e.due) begin
                    n_errors++;
                    $display("FAIL rsp1: rdata=%h err=%b cyc=%0d, required rdata=%h err=%b cyc=%0d",
                             a_rdata, a_err, cyc, e.rdata, e.err, e.due);
                end
            end
        end
        if (b_rsp_valid === 1'b1) begin
            n_checks++;
            if (qb.size() == 0) begin
                n_errors++;
                $display("FAIL rsp3_unexpected: pulse rdata=%h err=%b, required no response", b_rdata, b_err);
            end else begin
                e = qb.pop_front();
                if (b_rdata !== e.rdata || b_err !== e.err || cyc != e.due) begin
                    n_errors++;
                    $display("FAIL rsp3: rdata=%h err=%b cyc=%0d, required rdata=%h err=%b cyc=%0d",
                             b_rdata, b_err, cyc, e.rdata, e.err, e.due);
                end
            end
        end
    end

    // Called at posedge+1; drives one request, waits for acceptance, queues its expected response.
    task automatic issue(input bit sel, input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] exp_rdata, input logic exp_err);
        int unsigned tries = 0;
        rsp_t e;
        if (!sel) begin
            a_valid = 1'b1; a_we = we; a_f3 = f3; a_addr = addr; a_wdata = wdata;
        end else begin
            b_valid = 1'b1; b_we = we; b_f3 = f3; b_addr = addr; b_wdata = wdata;
        end
        while ((sel ? b_ready : a_ready) !== 1'b1 && tries < 8) begin
            @(posedge clk); #1;
            tries++;
        end
        n_checks++;
        if (tries >= 8) begin
            n_errors++;
            $display("FAIL issue_timeout: ready=0 after %0d cycles, required 1", tries);
        end else begin
            @(posedge clk); #1;
            e.rdata = exp_rdata;
            e.err   = exp_err;
            e.due   = cyc + (sel ? 32'd3 : 32'd1) - 1;
            if (sel) qb.push_back(e);
            else     qa.push_back(e);
        end
        if (!sel) a_valid = 1'b0;
        else      b_valid = 1'b0;
    endtask

    task automatic wait_idle(input bit sel);
        int unsigned n = 0;
        while ((sel ? qb.size() : qa.size()) != 0 && n < 20) begin
            @(posedge clk);
            n++;
        end
        #1;
        n_checks++;
        if (n >= 20) begin
            n_errors++;
            $display("FAIL wait_idle%0d: %0d responses outstanding, required 0", sel, sel ? qb.size() : qa.size());
        end
    endtask

    task automatic test_reset();
        a_valid = 1'b0; a_we = 1'b0; a_f3 = '0; a_addr = '0; a_wdata = '0;
        b_valid = 1'b0; b_we = 1'b0; b_f3 = '0; b_addr = '0; b_wdata = '0;
        #12;
        n_checks++;
        if ({a_rsp_valid, a_rdata, a_err, b_rsp_valid, b_rdata, b_err} !== '0) begin
            n_errors++;
            $display("FAIL reset_outputs: a=%b/%h/%b b=%b/%h/%b, required all 0",
                     a_rsp_valid, a_rdata, a_err, b_rsp_valid, b_rdata, b_err);
        end
        @(negedge clk);
        a_rst_n = 1'b1;
        b_rst_n = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (a_ready !== 1'b1 || b_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL reset_ready: ready=%b/%b, required 1/1", a_ready, b_ready);
        end
    endtask

    task automatic test_word_rw();
        issue(0, 1'b1, F3_W, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0);
        n_checks++;
        if (a_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL t1_ready_after_sw: ready=%b, required 1", a_ready);
        end
        issue(0, 1'b0, F3_W, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);
        n_checks++;
        if (a_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL t1_ready_after_lw: ready=%b, required 1", a_ready);
        end
        wait_idle(0);
    endtask

    task automatic test_byte();
        issue(0, 1'b1, F3_W,  32'h10, 32'h00000000, 32'h0, 1'b0);
        issue(0, 1'b1, F3_B,  32'h13, 32'h12345680, 32'h0, 1'b0);
        issue(0, 1'b0, F3_B,  32'h13, 32'h0, 32'hFFFFFF80, 1'b0);
        issue(0, 1'b0, F3_BU, 32'h13, 32'h0, 32'h00000080, 1'b0);
        issue(0, 1'b0, F3_W,  32'h10, 32'h0, 32'h80000000, 1'b0);
        wait_idle(0);
    endtask

    task automatic test_half();
        issue(0, 1'b1, F3_W,  32'h20, 32'h12345678, 32'h0, 1'b0);
        issue(0, 1'b1, F3_H,  32'h22, 32'hABCD8001, 32'h0, 1'b0);
        issue(0, 1'b0, F3_H,  32'h22, 32'h0, 32'hFFFF8001, 1'b0);
        issue(0, 1'b0, F3_HU, 32'h22, 32'h0, 32'h00008001, 1'b0);
        issue(0, 1'b0, F3_H,  32'h20, 32'h0, 32'h00005678, 1'b0);
        issue(0, 1'b0, F3_W,  32'h20, 32'h0, 32'h80015678, 1'b0);
        wait_idle(0);
    endtask

    task automatic test_errors();
        issue(0, 1'b1, F3_W,   32'h00, 32'h5A5A5A5A, 32'h0, 1'b0);
        issue(0, 1'b1, F3_W,   32'h04, 32'hA5A5A5A5, 32'h0, 1'b0);
        issue(0, 1'b0, F3_W,   32'h06, 32'h0, 32'h0, 1'b1);
        issue(0, 1'b1, F3_H,   32'h01, 32'hFFFFFFFF, 32'h0, 1'b1);
        issue(0, 1'b0, 3'b011, 32'h04, 32'h0, 32'h0, 1'b1);
        issue(0, 1'b0, F3_W,   32'(DEPTH*4), 32'h0, 32'h0, 1'b1);
        issue(0, 1'b1, F3_W,   32'(DEPTH*4), 32'hFFFFFFFF, 32'h0, 1'b1);
        issue(0, 1'b1, F3_BU,  32'h04, 32'hFFFFFFFF, 32'h0, 1'b1);
        issue(0, 1'b1, F3_W,   32'h02, 32'hFFFFFFFF, 32'h0, 1'b1);
        issue(0, 1'b0, F3_W,   32'h00, 32'h0, 32'h5A5A5A5A, 1'b0);
        issue(0, 1'b0, F3_W,   32'h04, 32'h0, 32'hA5A5A5A5, 1'b0);
        wait_idle(0);
    endtask

    task automatic test_latency3();
        issue(1, 1'b1, F3_W, 32'h40, 32'h11223344, 32'h0, 1'b0);
        issue(1, 1'b1, F3_W, 32'h44, 32'h55667788, 32'h0, 1'b0);
        wait_idle(1);
        b_valid = 1'b1; b_we = 1'b0; b_f3 = F3_W; b_addr = 32'h40; b_wdata = '0;
        n_checks++;
        if (b_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL t5_ready_idle: ready=%b, required 1", b_ready);
        end
        @(posedge clk); #1;
        b_valid = 1'b0;
        qb.push_back('{rdata: 32'h11223344, err: 1'b0, due: cyc + 2});
        for (int k = 1; k <= 2; k++) begin
            n_checks++;
            if (b_ready !== 1'b0 || b_rsp_valid !== 1'b0) begin
                n_errors++;
                $display("FAIL t5_wait_c%0d: ready=%b rsp_valid=%b, required 0/0", k, b_ready, b_rsp_valid);
            end
            @(posedge clk); #1;
        end
        n_checks++;
        if (b_ready !== 1'b1 || b_rsp_valid !== 1'b1) begin
            n_errors++;
            $display("FAIL t5_resp: ready=%b rsp_valid=%b, required 1/1", b_ready, b_rsp_valid);
        end
        issue(1, 1'b0, F3_W, 32'h44, 32'h0, 32'h55667788, 1'b0);
        n_checks++;
        if (b_ready !== 1'b0) begin
            n_errors++;
            $display("FAIL t5_accept_in_resp: ready=%b, required 0", b_ready);
        end
        wait_idle(1);
    endtask

    task automatic test_reset_mid();
        issue(1, 1'b1, F3_W, 32'h30, 32'hCAFEF00D, 32'h0, 1'b0);
        #2;
        b_rst_n = 1'b0;
        qb.delete();
        #1;
        n_checks++;
        if (b_rsp_valid !== 1'b0 || b_rdata !== 32'h0 || b_err !== 1'b0) begin
            n_errors++;
            $display("FAIL t6_reset_store: rsp=%b/%h/%b, required 0/0/0", b_rsp_valid, b_rdata, b_err);
        end
        repeat (2) @(negedge clk);
        b_rst_n = 1'b1;
        @(posedge clk); #1;
        issue(1, 1'b0, F3_W, 32'h40, 32'h0, 32'h11223344, 1'b0);
        #2;
        b_rst_n = 1'b0;
        qb.delete();
        #1;
        n_checks++;
        if (b_rsp_valid !== 1'b0 || b_rdata !== 32'h0 || b_err !== 1'b0) begin
            n_errors++;
            $display("FAIL t6_reset_load: rsp=%b/%h/%b, required 0/0/0", b_rsp_valid, b_rdata, b_err);
        end
        repeat (4) @(negedge clk);
        b_rst_n = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (b_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL t6_ready_after_reset: ready=%b, required 1", b_ready);
        end
        issue(1, 1'b0, F3_W, 32'h30, 32'h0, 32'hCAFEF00D, 1'b0);
        wait_idle(1);
    endtask

    initial begin
        test_reset();
        test_word_rw();
        test_byte();
        test_half();
        test_errors();
        test_latency3();
        test_reset_mid();
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (qa.size() != 0 || qb.size() != 0) begin
            n_errors++;
            $display("FAIL final_queues: outstanding=%0d/%0d, required 0/0", qa.size(), qb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/data_memory_lsu.md
Name: data_memory_lsu

Overview:
- Word-organised RV32I data memory with a valid/ready request port and a one-cycle-pulse response port.
- Generalises the single-word data memory in three ways:
  - parametrised depth and read latency;
  - byte/halfword/word stores with lane enables;
  - signed/unsigned sub-word loads.
- Reports misaligned, illegal and out-of-range accesses as errors instead of silently aliasing.
- Sits between the core's memory stage and the data RAM.

Parameters:
- DEPTH, 64, number of 32-bit words; power of two, at least 4.
- READ_LATENCY, 1, number of cycles from request acceptance to response; legal range 1..4.

Ports:
- clk  in  1  system clock; all state is updated on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request this cycle.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32I funct3 for the access size/sign.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- rsp_valid  out  1  response pulse, high for exactly one cycle.
- rsp_rdata  out  32  load result, already extended; 0 for stores and errors.
- rsp_err  out  1  access faulted; qualified by rsp_valid.

Behaviour:
- Accept: a request is accepted on a rising edge where req_valid && req_ready; every request gets exactly one response.
- Word index: AW = clog2(DEPTH); word index = req_addr[AW+1:2].
- Out of range: the access is out-of-range when req_addr[31:AW+2] != 0.
- Legal funct3, loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- Legal funct3, stores: 000 SB, 001 SH, 010 SW.
- Illegal funct3: any other funct3 is illegal (loads 011/110/111; stores 011 and 1xx).
- Misalignment: halfword with addr[0]=1 is misaligned; word with addr[1:0]!=0 is misaligned.
- Error response: for any of the above errors there is no memory write, and the response carries rsp_err=1, rsp_rdata=0.
- Stores, timing: the write commits on the acceptance edge.
- Stores, byte lanes:
  - SB writes lane addr[1:0] with wdata[7:0];
  - SH writes lanes {addr[1],0} and {addr[1],1} with wdata[15:0];
  - SW writes all four lanes.
  - Other lanes are unchanged.
- Loads, sampling: the word is read on the acceptance edge.
- Loads, extraction:
  - byte lane addr[1:0] or half at addr[1]*16;
  - LB/LH sign-extend;
  - LBU/LHU zero-extend;
  - LW is passed through.
- Loads, holding: the extracted result is held in an output register until the response.
- FSM states:
  - IDLE: req_ready=1.
  - WAIT: req_ready=0; down-counter loaded with READ_LATENCY-1.
  - RESP: rsp_valid=1 for this cycle.
- FSM transitions:
  - IDLE + accept -> RESP if READ_LATENCY=1, else WAIT.
  - WAIT counts down each cycle -> RESP when the counter reaches 0.
  - RESP -> IDLE, or RESP -> RESP/WAIT if a new request is accepted in the same cycle.
- req_ready is 1 in IDLE and RESP. With READ_LATENCY=1 this gives one access per cycle back-to-back.
- Response timing: the response for a request accepted on edge T is visible in the cycle after edge T+READ_LATENCY-1, i.e. exactly READ_LATENCY cycles later.
- Store followed by load to the same word, back-to-back: the load returns the newly written data (the write occurs on the earlier edge).
- Reset values: state=IDLE, counter=0, rsp_valid=0, rsp_rdata=0, rsp_err=0. req_ready=1 once reset is released.
- Reset mid-operation: a pending response is discarded. A store already accepted remains committed.
- Memory contents are not reset.
- req_* inputs are ignored when req_ready=0; no stall beyond the fixed latency.

Decomposition:
- Shared package dmem_pkg holds:
  - funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU;
  - the FSM state enum {IDLE, WAIT, RESP};
  - error-cause helper constants.
- One combinational sub-module, dmem_lane_align. It is used by both the store path and the load path.
  - Store direction: produces the 4-bit byte-enable and lane-shifted write data from funct3/addr[1:0]/wdata.
  - Load direction: produces the extended load data from the raw word.
  - It also produces the misaligned/illegal flags.

Test Plan:
- Test 1: SW 0xDEADBEEF @0x10, then LW @0x10, READ_LATENCY=1 -> second response rdata=0xDEADBEEF, err=0; req_ready stays 1 throughout.
- Test 2: SB 0x80 @0x13 over word 0x00000000, then LB @0x13 and LBU @0x13 -> 0xFFFFFF80 and 0x00000080; LW @0x10 -> 0x80000000.
- Test 3: SH 0x8001 @0x22, then LH @0x22 and LHU @0x22 -> 0xFFFF8001 and 0x00008001; LH @0x20 -> previous lower half unchanged.
- Test 4: LW @0x06, SH @0x01, load funct3=011, LW @(DEPTH*4) -> each rsp_err=1, rdata=0; memory unchanged on re-read.
- Test 5: READ_LATENCY=3, LW accepted on edge T -> req_ready=0 for two cycles; rsp_valid high only in the third cycle after T; next request accepted in that RESP cycle.
- Test 6: rst_n driven low in WAIT (READ_LATENCY=3) after a store-accept -> rsp_valid never pulses; outputs read 0 asynchronously; a later LW returns the stored value.
